// File: rtl/data_sram_responder_pkg.sv
// Shared types, defaults and helpers for the data SRAM responder.
package data_sram_responder_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_LATENCY     = 2;
  localparam int unsigned CNT_W               = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-lane merge: lanes with wen set take new data, others keep the old word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  wen);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/data_sram_responder_sram_array.sv
// Single-port word storage with per-byte write enables and a registered read.
module sram_array
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH_WORDS,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] merged;

  assign merged = merge_lanes(mem_q[addr], wdata, we);

  // Read port returns the post-merge word, so a write echoes what was stored.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= merged;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Request acceptance, wait timer and out-of-range handling in front of sram_array.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_rdata,
  output logic        mem_oob
);

  // state   | meaning
  // IDLE    | no request in flight, ready to accept
  // WAIT    | request captured, counting down wait cycles
  // RESP    | response cycle; a new request may be accepted here

  localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [29:0]      word_q;
  logic [3:0]       wen_q;
  logic [31:0]      wdata_q;
  logic             addr_ok_q;
  logic             data_ok_q;
  logic             oob_q;
  logic             rdata_zero_q;

  logic             accept;
  logic             acc_fire;
  logic [29:0]      acc_word;
  logic [3:0]       acc_wen;
  logic [31:0]      acc_wdata;
  logic             acc_oob;
  logic [31:0]      sram_rdata;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[1:0];
  assign accept          = mem_en & addr_ok_q;

  // With zero latency the storage access coincides with the accept edge,
  // so the live request is used instead of the captured copy.
  always_comb begin
    acc_fire  = 1'b0;
    acc_word  = word_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;
    if (LATENCY == 0) begin
      acc_fire  = accept;
      acc_word  = mem_addr[31:2];
      acc_wen   = mem_wen;
      acc_wdata = mem_wdata;
    end else begin
      acc_fire  = (state_q == ST_WAIT) && (cnt_q == '0);
    end
  end

  assign acc_oob = ({2'b00, acc_word} >= 32'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      addr_ok_q    <= 1'b1;
      data_ok_q    <= 1'b0;
      oob_q        <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      data_ok_q <= acc_fire;
      oob_q     <= acc_fire & acc_oob;
      if (acc_fire) rdata_zero_q <= acc_oob;
      if (accept) begin
        word_q  <= mem_addr[31:2];
        wen_q   <= mem_wen;
        wdata_q <= mem_wdata;
      end
      unique case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept && LATENCY == 0) begin
            state_q   <= ST_RESP;
            addr_ok_q <= 1'b1;
          end else if (accept) begin
            state_q   <= ST_WAIT;
            cnt_q     <= CNT_INIT;
            addr_ok_q <= 1'b0;
          end else begin
            state_q   <= ST_IDLE;
            addr_ok_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q   <= ST_RESP;
            addr_ok_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          addr_ok_q <= 1'b1;
        end
      endcase
    end
  end

  sram_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (acc_fire & ~acc_oob),
    .we    (acc_wen),
    .addr  (acc_word[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (sram_rdata)
  );

  assign mem_addr_ok = addr_ok_q;
  assign mem_data_ok = data_ok_q;
  assign mem_oob     = oob_q;
  assign mem_rdata   = rdata_zero_q ? 32'h0000_0000 : sram_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: LATENCY=2 instance (A) and LATENCY=0 instance (B).
module tb_data_sram_responder;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en_a = 0, en_b = 0;
  logic [3:0]  wen_a = 0, wen_b = 0;
  logic [31:0] addr_a = 0, addr_b = 0, wdata_a = 0, wdata_b = 0;
  logic        addr_ok_a, addr_ok_b, data_ok_a, data_ok_b, oob_a, oob_b;
  logic [31:0] rdata_a, rdata_b;

  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .mem_en(en_a), .mem_wen(wen_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_addr_ok(addr_ok_a), .mem_data_ok(data_ok_a),
    .mem_rdata(rdata_a), .mem_oob(oob_a));

  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .mem_en(en_b), .mem_wen(wen_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_addr_ok(addr_ok_b), .mem_data_ok(data_ok_b),
    .mem_rdata(rdata_b), .mem_oob(oob_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_oob;
  } vec_t;

  vec_t vq[$];

  // One request on A, issued at #1 after an edge; returns #1 after the response edge.
  task automatic req_a(input string name, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_oob);
    int lat;
    chk({name, " addr_ok before"}, 32'(addr_ok_a), 32'd1);
    en_a = 1'b1; wen_a = wen; addr_a = addr; wdata_a = wdata;
    @(posedge clk); #1;
    en_a = 1'b0; wen_a = 4'h0; addr_a = 32'h0; wdata_a = 32'h0;
    chk({name, " addr_ok in wait"}, 32'(addr_ok_a), 32'd0);
    lat = 0;
    while (data_ok_a !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(LAT_A));
    chk({name, " rdata"}, rdata_a, exp_rd);
    chk({name, " oob"}, 32'(oob_a), 32'(exp_oob));
  endtask

  logic [31:0] mdl_b [1024];
  logic [31:0] exp_rd_b = 32'h0;

  // One cycle on B (zero latency): response is visible #1 after the accept edge.
  task automatic step_b(input string name, input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] w;
    logic        oob;
    chk({name, " addr_ok"}, 32'(addr_ok_b), 32'd1);
    en_b = en; wen_b = wen; addr_b = addr; wdata_b = wdata;
    oob = (addr[31:12] != 20'h0);
    if (en) begin
      if (oob) exp_rd_b = 32'h0;
      else begin
        w = mdl_b[addr[11:2]];
        for (int i = 0; i < 4; i++)
          if (wen[i]) w[8*i +: 8] = wdata[8*i +: 8];
        mdl_b[addr[11:2]] = w;
        exp_rd_b = w;
      end
    end
    @(posedge clk); #1;
    en_b = 1'b0;
    chk({name, " data_ok"}, 32'(data_ok_b), 32'(en));
    chk({name, " oob"}, 32'(oob_b), 32'(en & oob));
    chk({name, " rdata"}, rdata_b, exp_rd_b);
  endtask

  initial begin
    int pulses;
    logic [31:0] a;

    vq.push_back('{"w full 0x100",    4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
    vq.push_back('{"r 0x100",         4'b0000, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vq.push_back('{"w lane2 0x100",   4'b0100, 32'h0000_0100, 32'h5555_5555, 32'hDE55_BEEF, 1'b0});
    vq.push_back('{"r merged 0x100",  4'b0000, 32'h0000_0100, 32'h0,         32'hDE55_BEEF, 1'b0});
    vq.push_back('{"w full 0x0",      4'b1111, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b0});
    vq.push_back('{"r oob 0x1000",    4'b0000, 32'h0000_1000, 32'h0,         32'h0,         1'b1});
    vq.push_back('{"w oob 0x1000",    4'b1111, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,         1'b1});
    vq.push_back('{"r 0x0 unchanged", 4'b0000, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0});
    vq.push_back('{"w lane0 0x103",   4'b0001, 32'h0000_0103, 32'h0000_00AA, 32'hDE55_BEAA, 1'b0});
    vq.push_back('{"w last word",     4'b1111, 32'h0000_0FFC, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0});
    vq.push_back('{"r last word",     4'b0000, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0});
    vq.push_back('{"r oob top",       4'b0000, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1});
    vq.push_back('{"w full 0x200",    4'b1111, 32'h0000_0200, 32'h1111_2222, 32'h1111_2222, 1'b0});

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset addr_ok", 32'(addr_ok_a), 32'd1);
    chk("reset data_ok", 32'(data_ok_a), 32'd0);
    chk("reset oob", 32'(oob_a), 32'd0);
    chk("reset rdata", rdata_a, 32'h0);
    chk("reset rdata b", rdata_b, 32'h0);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors, issued back to back so each new request is accepted in RESP.
    foreach (vq[i])
      req_a(vq[i].name, vq[i].wen, vq[i].addr, vq[i].wdata, vq[i].exp_rd, vq[i].exp_oob);
    @(posedge clk); #1;
    chk("pulse ends", 32'(data_ok_a), 32'd0);
    chk("oob ends", 32'(oob_a), 32'd0);
    chk("rdata holds", rdata_a, 32'h1111_2222);

    // mem_en pulsed during WAIT is ignored.
    en_a = 1'b1; wen_a = 4'b0000; addr_a = 32'h0;
    @(posedge clk); #1;
    wen_a = 4'b1111; wdata_a = 32'h0;
    chk("wait pulse addr_ok", 32'(addr_ok_a), 32'd0);
    @(posedge clk); #1;
    en_a = 1'b0; wen_a = 4'h0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (data_ok_a === 1'b1) begin
        pulses++;
        chk("wait pulse rdata", rdata_a, 32'h1234_5678);
      end
      @(posedge clk); #1;
    end
    chk("wait pulse count", 32'(pulses), 32'd1);
    req_a("r 0x0 after pulse", 4'b0000, 32'h0, 32'h0, 32'h1234_5678, 1'b0);

    // Reset during WAIT of a write discards it.
    en_a = 1'b1; wen_a = 4'b1111; addr_a = 32'h200; wdata_a = 32'h9999_9999;
    @(posedge clk); #1;
    en_a = 1'b0; wen_a = 4'h0;
    #1 rst = 1'b0;
    #1;
    chk("rst addr_ok", 32'(addr_ok_a), 32'd1);
    chk("rst rdata", rdata_a, 32'h0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst = 1'b1;
      @(posedge clk); #1;
      if (data_ok_a === 1'b1) pulses++;
    end
    chk("rst no data_ok", 32'(pulses), 32'd0);
    req_a("r 0x200 after rst", 4'b0000, 32'h200, 32'h0, 32'h1111_2222, 1'b0);

    // B: initialise words 0..15 with mem_en held high, then 6 back-to-back reads.
    for (int w = 0; w < 16; w++)
      step_b("b init", 1'b1, 4'b1111, 32'(w * 4), $urandom);
    for (int w = 0; w < 6; w++)
      step_b("b b2b read", 1'b1, 4'b0000, 32'(w * 4 + 8), 32'h0);

    // B: randomized traffic against the array model.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
      else a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      step_b("b rand", ($urandom_range(0, 3) != 0), 4'($urandom), a, $urandom);
    end
    step_b("b idle", 1'b0, 4'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
